// File: rtl/apb_transfer_controller.sv
// APB sequencer for the AHB-to-APB bridge: buffers requests in a small FIFO and
// turns each one into an APB SETUP/ACCESS cycle, with an optional Pready timeout.
module apb_transfer_controller #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 15,
  parameter int SEL_LSB = 28
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        valid,
  input  logic [31:0] Haddr_temp,
  input  logic [31:0] Hwdata_temp,
  input  logic        Hwrite_temp,
  output logic        Hready,
  output logic [31:0] Hrdata,
  output logic        Hresp,
  output logic        done,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Pwrite,
  output logic [3:0]  Psel,
  output logic        Penable,
  input  logic        Pready,
  input  logic [31:0] Prdata,
  input  logic        Pslverr,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [TW-1:0] TCNT_ONE = TW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t state_q;

  logic [31:0]   addr_mem  [DEPTH];
  logic [31:0]   wdata_mem [DEPTH];
  logic          write_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] tcnt_q;

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        timeout_hit;
  logic        xfer_end;
  logic [31:0] head_addr;
  logic [31:0] head_wdata;
  logic        head_write;

  function automatic logic [3:0] sel_onehot(input logic [31:0] addr);
    sel_onehot = 4'b0001 << addr[SEL_LSB +: 2];
  endfunction

  // Handshake: a request is taken on every rising edge where valid & Hready.
  // Hready depends only on registered occupancy, so a pop on the same edge
  // never lets a full FIFO accept another entry.
  assign fifo_empty  = (count_q == '0);
  assign Hready      = (count_q != FULL_CNT);
  assign push        = valid & Hready;
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TO_LAST);
  assign xfer_end    = (state_q == S_ACCESS) && (Pready || timeout_hit);
  assign pop         = !fifo_empty && ((state_q == S_IDLE) || xfer_end);

  assign head_addr   = addr_mem[rd_ptr_q];
  assign head_wdata  = wdata_mem[rd_ptr_q];
  assign head_write  = write_mem[rd_ptr_q];
  assign dbg_state_o = state_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge Hclk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= Haddr_temp;
      wdata_mem[wr_ptr_q] <= Hwdata_temp;
      write_mem[wr_ptr_q] <= Hwrite_temp;
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      Hrdata  <= '0;
      Hresp   <= 1'b0;
      done    <= 1'b0;
      Paddr   <= '0;
      Pwdata  <= '0;
      Pwrite  <= 1'b0;
      Psel    <= '0;
      Penable <= 1'b0;
    end else begin
      done  <= 1'b0;
      Hresp <= 1'b0;
      if (pop) begin
        Paddr  <= head_addr;
        Pwdata <= head_wdata;
        Pwrite <= head_write;
      end
      case (state_q)
        S_IDLE: begin
          Penable <= 1'b0;
          if (pop) begin
            state_q <= S_SETUP;
            Psel    <= sel_onehot(head_addr);
          end else begin
            Psel <= '0;
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
          Penable <= 1'b1;
          tcnt_q  <= '0;
        end
        S_ACCESS: begin
          if (xfer_end) begin
            // Pready wins over a coinciding timeout; an abort leaves Hrdata alone.
            done    <= 1'b1;
            Hresp   <= Pready ? Pslverr : 1'b1;
            Penable <= 1'b0;
            if (Pready && !Pwrite) Hrdata <= Prdata;
            if (pop) begin
              state_q <= S_SETUP;
              Psel    <= sel_onehot(head_addr);
            end else begin
              state_q <= S_IDLE;
              Psel    <= '0;
            end
          end else begin
            tcnt_q <= tcnt_q + TCNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          Psel    <= '0;
          Penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_transfer_controller.sv
// Bench for apb_transfer_controller: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_apb_transfer_controller;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 15;
  localparam int SEL_LSB = 28;

  // Clock / reset
  logic Hclk   = 1'b0;
  logic Hreset = 1'b1;
  always #5 Hclk = ~Hclk;

  logic        valid       = 1'b0;
  logic [31:0] Haddr_temp  = '0;
  logic [31:0] Hwdata_temp = '0;
  logic        Hwrite_temp = 1'b0;
  logic        Pready      = 1'b0;
  logic [31:0] Prdata      = '0;
  logic        Pslverr     = 1'b0;
  logic        Hready;
  logic [31:0] Hrdata;
  logic        Hresp;
  logic        done;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic [3:0]  Psel;
  logic        Penable;
  logic [1:0]  dbg_state;

  apb_transfer_controller #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SEL_LSB(SEL_LSB)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid),
    .Haddr_temp(Haddr_temp), .Hwdata_temp(Hwdata_temp), .Hwrite_temp(Hwrite_temp),
    .Hready(Hready), .Hrdata(Hrdata), .Hresp(Hresp), .done(done),
    .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable),
    .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr), .dbg_state_o(dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting requests plus the one being served,
  // tracked by its age (0 = setup cycle, n = n-th access cycle).
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } req_t;

  req_t        pend_q[$];
  req_t        cur      = '0;
  bit          busy     = 1'b0;
  int          age      = 0;
  logic [31:0] m_paddr  = '0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_hrdata = '0;
  logic        m_pwrite = 1'b0;
  logic        m_done   = 1'b0;
  logic        m_hresp  = 1'b0;

  task automatic model_clear();
    pend_q.delete();
    busy     = 1'b0;
    age      = 0;
    m_paddr  = '0;
    m_pwdata = '0;
    m_hrdata = '0;
    m_pwrite = 1'b0;
    m_done   = 1'b0;
    m_hresp  = 1'b0;
  endtask

  task automatic model_step();
    bit had_pending;
    bit can_push;
    had_pending = (pend_q.size() > 0);
    can_push    = (pend_q.size() < DEPTH);
    m_done  = 1'b0;
    m_hresp = 1'b0;
    if (busy) begin
      if (age == 0) begin
        age = 1;
      end else if (Pready) begin
        m_done  = 1'b1;
        m_hresp = Pslverr;
        if (!cur.write) m_hrdata = Prdata;
        busy = 1'b0;
      end else if (TIMEOUT != 0 && age == TIMEOUT) begin
        m_done  = 1'b1;
        m_hresp = 1'b1;
        busy    = 1'b0;
      end else begin
        age++;
      end
    end
    if (!busy && had_pending) begin
      cur      = pend_q.pop_front();
      busy     = 1'b1;
      age      = 0;
      m_paddr  = cur.addr;
      m_pwdata = cur.wdata;
      m_pwrite = cur.write;
    end
    if (valid && can_push) pend_q.push_back({Haddr_temp, Hwdata_temp, Hwrite_temp});
  endtask

  initial begin
    forever begin
      @(posedge Hclk or posedge Hreset);
      if (Hreset) model_clear();
      else model_step();
    end
  end

  // Scoreboard compare, every cycle, away from the rising edge
  initial begin
    forever begin
      @(negedge Hclk);
      check("Hready",  32'(Hready),  32'(pend_q.size() < DEPTH));
      check("Psel",    32'(Psel),    busy ? (32'd1 << cur.addr[SEL_LSB +: 2]) : 32'd0);
      check("Penable", 32'(Penable), 32'(busy && age >= 1));
      check("Paddr",   Paddr,        m_paddr);
      check("Pwdata",  Pwdata,       m_pwdata);
      check("Pwrite",  32'(Pwrite),  32'(m_pwrite));
      check("Hrdata",  Hrdata,       m_hrdata);
      check("done",    32'(done),    32'(m_done));
      check("Hresp",   32'(Hresp),   32'(m_hresp));
    end
  end

  // Driver tasks
  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic w);
    valid       = 1'b1;
    Haddr_temp  = a;
    Hwdata_temp = d;
    Hwrite_temp = w;
  endtask

  task automatic fill_three_writes();
    Pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
      @(negedge Hclk);
    end
    valid = 1'b0;
  endtask

  initial begin
    int  pen;
    int  ndone;
    int  last;
    int  gap_bad;
    int  psel_seen;
    bit  seen;
    logic resp0;
    logic resp1;
    logic [31:0] hr;
    int  mode;

    repeat (2) @(negedge Hclk);
    check("rst_hready",  32'(Hready),  32'd1);
    check("rst_psel",    32'(Psel),    32'd0);
    check("rst_penable", 32'(Penable), 32'd0);
    check("rst_hrdata",  Hrdata,       32'd0);
    check("rst_paddr",   Paddr,        32'd0);
    check("rst_done",    32'(done),    32'd0);
    Hreset = 1'b0;

    // Single write to slave 2, Pready immediately
    @(negedge Hclk);
    drive_req(32'h2000_0010, 32'hDEAD_BEEF, 1'b1);
    Pready  = 1'b1;
    Pslverr = 1'b0;
    @(negedge Hclk);
    valid = 1'b0;
    @(negedge Hclk);
    check("t1_setup_psel",    32'(Psel),    32'b0100);
    check("t1_setup_penable", 32'(Penable), 32'd0);
    @(negedge Hclk);
    check("t1_access_penable", 32'(Penable), 32'd1);
    check("t1_access_paddr",   Paddr,        32'h2000_0010);
    @(negedge Hclk);
    check("t1_done",  32'(done),  32'd1);
    check("t1_hresp", 32'(Hresp), 32'd0);
    @(negedge Hclk);
    check("t1_done_pulse", 32'(done), 32'd0);

    // Read with Pready delayed three access cycles
    Pready = 1'b0;
    Prdata = 32'h1234_5678;
    drive_req(32'h0000_0004, 32'h0, 1'b0);
    pen  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Hclk);
      valid = 1'b0;
      if (done) begin
        seen = 1'b1;
        check("t2_hrdata", Hrdata, 32'h1234_5678);
      end else begin
        if (Penable) pen++;
        Pready = (pen >= 4);
      end
    end
    check("t2_done_seen",      32'(seen), 32'd1);
    check("t2_penable_cycles", 32'(pen),  32'd4);
    Pready = 1'b0;

    // Fill: one in flight, two queued, fourth request refused
    fill_three_writes();
    check("t3_hready_full", 32'(Hready), 32'd0);
    repeat (2) @(negedge Hclk);
    check("t3_hready_still_full", 32'(Hready), 32'd0);
    Pready  = 1'b1;
    ndone   = 0;
    last    = 0;
    gap_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Hclk);
      if (done) begin
        if (ndone > 0 && i - last != 2) gap_bad++;
        last = i;
        ndone++;
      end
    end
    check("t3_drained",    32'(ndone),   32'd3);
    check("t3_gap_errors", 32'(gap_bad), 32'd0);

    // Slave error on slave 3, following transfer completes cleanly
    Pslverr = 1'b1;
    drive_req(32'h3000_0000, 32'h5555_AAAA, 1'b1);
    @(negedge Hclk);
    drive_req(32'h1000_0008, 32'h0BAD_F00D, 1'b1);
    @(negedge Hclk);
    valid = 1'b0;
    check("t4_psel_slave3", 32'(Psel), 32'b1000);
    ndone = 0;
    resp0 = 1'b0;
    resp1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Hclk);
      if (done) begin
        if (ndone == 0) begin
          resp0   = Hresp;
          Pslverr = 1'b0;
        end else begin
          resp1 = Hresp;
        end
        ndone++;
      end
    end
    check("t4_count",        32'(ndone), 32'd2);
    check("t4_first_hresp",  32'(resp0), 32'd1);
    check("t4_second_hresp", 32'(resp1), 32'd0);

    // Timeout abort of a read
    Pready = 1'b0;
    Prdata = 32'hCAFE_0000;
    drive_req(32'h0000_0100, 32'h0, 1'b0);
    pen   = 0;
    seen  = 1'b0;
    resp0 = 1'b0;
    hr    = '0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Hclk);
      valid = 1'b0;
      if (done) begin
        seen  = 1'b1;
        resp0 = Hresp;
        hr    = Hrdata;
      end else if (Penable) begin
        pen++;
      end
    end
    check("t5_done_seen",      32'(seen),  32'd1);
    check("t5_access_cycles",  32'(pen),   32'd15);
    check("t5_hresp",          32'(resp0), 32'd1);
    check("t5_hrdata_kept",    hr,         32'h1234_5678);
    @(negedge Hclk);
    check("t5_idle_psel",    32'(Psel),    32'd0);
    check("t5_idle_penable", 32'(Penable), 32'd0);

    // Reset mid-access with two requests queued
    fill_three_writes();
    #2 Hreset = 1'b1;
    #1;
    check("t6_rst_psel",    32'(Psel),    32'd0);
    check("t6_rst_penable", 32'(Penable), 32'd0);
    check("t6_rst_hready",  32'(Hready),  32'd1);
    @(negedge Hclk);
    Hreset    = 1'b0;
    Pready    = 1'b1;
    ndone     = 0;
    psel_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Hclk);
      if (done) ndone++;
      if (Psel != 4'b0000) psel_seen++;
    end
    check("t6_no_done", 32'(ndone),     32'd0);
    check("t6_no_psel", 32'(psel_seen), 32'd0);

    // Random traffic with bursts of slow or silent slaves
    mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge Hclk);
      if (cyc % 64 == 0) mode = $urandom_range(0, 3);
      valid       = ($urandom_range(0, 99) < 45);
      Haddr_temp  = $urandom();
      Hwdata_temp = $urandom();
      Hwrite_temp = 1'($urandom_range(0, 1));
      Prdata      = $urandom();
      Pslverr     = ($urandom_range(0, 3) == 0);
      case (mode)
        0:       Pready = ($urandom_range(0, 99) < 70);
        1:       Pready = 1'b1;
        2:       Pready = 1'b0;
        default: Pready = ($urandom_range(0, 99) < 8);
      endcase
      #2 Hreset = ($urandom_range(0, 399) == 0);
    end
    @(negedge Hclk);
    valid  = 1'b0;
    Hreset = 1'b0;
    Pready = 1'b1;
    repeat (10) @(negedge Hclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
